// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - byte-write UART transmitter with transmit FIFO and programmable bit divider
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   data_write     one-cycle pulse, enqueue data_in
//   data_in[7:0]   byte to enqueue
//   div_write      one-cycle pulse, load div_in into the bit-period divider
//   div_in[15:0]   clocks per UART bit (values below 4 are stored as 4)
//   overflow_clear clears the sticky overflow flag
//   tx             serial output, idle high, 8N1 framing
//   busy           frame in progress or bytes waiting
//   fifo_count     bytes waiting in the FIFO (excludes the byte being shifted)
//   fifo_full      fifo_count == FIFO_DEPTH
//   overflow       sticky: a write was dropped because the FIFO was full

module wb_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd104
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_write,
    input  logic [7:0]  data_in,
    input  logic        div_write,
    input  logic [15:0] div_in,
    input  logic        overflow_clear,
    output logic        tx,
    output logic        busy,
    output logic [3:0]  fifo_count,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [3:0]      count;
    logic [15:0]     div_reg;
    logic [15:0]     div_frame;
    logic [15:0]     bit_cnt;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic            bit_done;
    logic            fifo_empty;
    logic            pop;
    logic            push;

    assign fifo_empty = (count == 4'd0);
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !fifo_empty;

    // Last cycle of the current bit, measured against the divider latched at the start bit.
    assign bit_done = (bit_cnt == (div_frame - 16'd1));

    // The shifter takes the head either from IDLE or on the final stop cycle,
    // which gives back-to-back frames with no idle gap.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    assign push = data_write && (!fifo_full || pop);

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear when both happen in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (data_write && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_reg <= DIV_RESET;
        end else if (div_write) begin
            div_reg <= (div_in < 16'd4) ? 16'd4 : div_in;
        end
    end

    // tx is registered so that it changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            div_frame <= DIV_RESET;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state     <= START;
                        shreg     <= mem[rd_ptr];
                        div_frame <= div_reg;
                        bit_cnt   <= 16'd0;
                        tx        <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= 16'd0;
                        if (pop) begin
                            state     <= START;
                            shreg     <= mem[rd_ptr];
                            div_frame <= div_reg;
                            tx        <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb/tb_wb_uart_tx.sv - randomized self-checking bench for wb_uart_tx against a frame-level model

module tb_wb_uart_tx;

    localparam int          DEPTH = 8;
    localparam logic [15:0] DIVR  = 16'd104;

    logic        clk;
    logic        reset_n;
    logic        data_write;
    logic [7:0]  data_in;
    logic        div_write;
    logic [15:0] div_in;
    logic        overflow_clear;
    logic        tx;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;

    wb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_write     (data_write),
        .data_in        (data_in),
        .div_write      (div_write),
        .div_in         (div_in),
        .overflow_clear (overflow_clear),
        .tx             (tx),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: a byte queue plus the timeline of the frame currently on the line.
    logic [7:0]  q[$];
    logic        m_active = 1'b0;
    int          m_start = 0;
    int          m_end = 0;
    int          m_fdiv = 4;
    logic [7:0]  m_byte = 8'd0;
    logic [15:0] m_div = DIVR;
    logic        m_ovf = 1'b0;
    int          p = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, p, got, exp);
        end
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] d, input logic dw,
                              input logic [15:0] dv, input logic oc, input logic rn);
        logic free;
        if (!rn) begin
            q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_div    = DIVR;
            return;
        end
        free = !m_active || (p >= m_end);
        if (m_active && p >= m_end) m_active = 1'b0;
        if (free && q.size() > 0) begin
            m_byte   = q.pop_front();
            m_fdiv   = int'(m_div);
            m_start  = p;
            m_end    = p + 10 * m_fdiv;
            m_active = 1'b1;
        end
        if (wr && q.size() == DEPTH) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (wr && q.size() < DEPTH) q.push_back(d);
        if (dw) m_div = (dv < 16'd4) ? 16'd4 : dv;
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active || p >= m_end) return 1'b1;
        k = (p - m_start) / m_fdiv;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    task automatic cyc(input logic wr, input logic [7:0] d, input logic dw,
                       input logic [15:0] dv, input logic oc, input logic rn);
        data_write     = wr;
        data_in        = d;
        div_write      = dw;
        div_in         = dv;
        overflow_clear = oc;
        reset_n        = rn;
        @(posedge clk);
        model_edge(wr, d, dw, dv, oc, rn);
        #1;
        check("tx", 32'(tx), 32'(exp_tx()));
        check("busy", 32'(busy), 32'((m_active && p < m_end) || q.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        p++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic set_div(input logic [15:0] v);
        cyc(1'b0, 8'd0, 1'b1, v, 1'b0, 1'b1);
    endtask

    initial begin
        data_write = 1'b0; data_in = 8'd0; div_write = 1'b0;
        div_in = 16'd0; overflow_clear = 1'b0; reset_n = 1'b0;

        cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        idle(3);

        // Divider of 2 clamps to 4; single 0xA5 frame.
        set_div(16'd2);
        idle(2);
        wr_byte(8'hA5);
        idle(50);

        // Three back-to-back frames.
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        idle(130);

        // Overflow at div=16, then clear; second burst with clear and dropped write together.
        set_div(16'd16);
        for (int i = 0; i < 10; i++) wr_byte(8'(8'h30 + i));
        idle(5);
        cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 1'b1);
        idle(1500);
        for (int i = 0; i < 10; i++) wr_byte(8'(8'h50 + i));
        cyc(1'b1, 8'hEE, 1'b0, 16'd0, 1'b1, 1'b1);
        idle(3);
        cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 1'b1);
        idle(1500);

        // Reset during data bit 3 at div=8, with bytes still queued.
        set_div(16'd8);
        wr_byte(8'h96); wr_byte(8'h11); wr_byte(8'h22);
        idle(33);
        cyc(1'b0, 8'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        idle(40);

        // Divider change mid-frame applies only to the next frame.
        set_div(16'd8);
        wr_byte(8'hC3); wr_byte(8'h3C);
        idle(20);
        set_div(16'd4);
        idle(130);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            logic wr, dw, oc, rn;
            wr = ($urandom_range(0, 5) == 0);
            dw = ($urandom_range(0, 199) == 0);
            oc = ($urandom_range(0, 49) == 0);
            rn = ($urandom_range(0, 2999) != 0);
            cyc(wr, 8'($urandom), dw, 16'($urandom_range(0, 12)), oc, rn);
        end
        idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
